spi_slave_tx_serializer: RTL and testbench

- Consumer-side reader for the SPI slave's clock-domain-crossing FIFO.
- Pops DATA_WIDTH-bit words through a valid/ready handshake and serialises them MSB-first onto a single-bit stream, one bit per tx_shift strobe.
- Transfer length is programmable in bits and independent of word size.
- Holds a one-word prefetch buffer so the bit stream has no gap at word boundaries.

---
 rtl/spi_slave_tx_serializer_if.sv | 30 +++
 rtl/spi_slave_tx_serializer.sv | 182 ++++++++++++++++++
 tb/tb_spi_slave_tx_serializer.sv | 374 +++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/spi_slave_tx_serializer_if.sv
// -----------------------------------------------------------------------------
// spi_slave_tx_serializer_if
//   Read-side handshake of the SPI slave CDC FIFO as seen by the TX serializer.
//
//   data_i   word presented by the FIFO
//   valid_i  data_i is valid
//   ready_o  serializer accepts the word on a clock edge where valid_i is high
//
//   master : FIFO side (drives data_i / valid_i)
//   slave  : serializer side (drives ready_o)
// -----------------------------------------------------------------------------
interface spi_slave_tx_serializer_if #(
    parameter int DATA_WIDTH = 32
) ();
    logic [DATA_WIDTH-1:0] data_i;
    logic                  valid_i;
    logic                  ready_o;

    modport master (
        output data_i,
        output valid_i,
        input  ready_o
    );

    modport slave (
        input  data_i,
        input  valid_i,
        output ready_o
    );
endinterface

// File: rtl/spi_slave_tx_serializer.sv
// -----------------------------------------------------------------------------
// spi_slave_tx_serializer
//   Pops words from the SPI slave CDC FIFO and serialises them MSB-first onto
//   sdo, one bit per tx_shift strobe. The transfer length is counted in bits
//   and is independent of the word size. A one-word prefetch buffer keeps the
//   bit stream gap-free across word boundaries.
//
//   clk       single clock
//   rstn      synchronous active-low reset
//   fifo      FIFO read handshake (data_i, valid_i in; ready_o out)
//   tx_start  one-cycle pulse starting a transfer (ignored while busy)
//   tx_len    transfer length in bits minus 1, sampled on tx_start
//   tx_shift  one-cycle strobe advancing the stream by one bit
//   sdo       current serial bit (registered)
//   tx_busy   transfer in progress
//   tx_done   one-cycle pulse after the last bit has been shifted
//   underrun  one-cycle pulse when a bit is shifted with no word loaded
//
//   state  | meaning
//   -------+-----------------------------------------------------------
//   IDLE   | no transfer; FIFO not read, tx_shift ignored
//   ACTIVE | transfer running; prefetching words and shifting bits out
// -----------------------------------------------------------------------------
module spi_slave_tx_serializer #(
    parameter int DATA_WIDTH = 32,
    parameter int LEN_W      = 16
) (
    input  logic                        clk,
    input  logic                        rstn,
    spi_slave_tx_serializer_if.slave    fifo,
    input  logic                        tx_start,
    input  logic [LEN_W-1:0]            tx_len,
    input  logic                        tx_shift,
    output logic                        sdo,
    output logic                        tx_busy,
    output logic                        tx_done,
    output logic                        underrun
);

    localparam int CNT_W = $clog2(DATA_WIDTH + 1);

    // bits_left is one bit wider than tx_len so that tx_len = all ones
    // (2^LEN_W bits) does not wrap to zero.
    localparam logic [LEN_W:0]   BL_ONE   = (LEN_W + 1)'(1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DATA_WIDTH);

    typedef enum logic {
        IDLE   = 1'b0,
        ACTIVE = 1'b1
    } state_t;

    state_t                state_q, state_d;
    logic [LEN_W:0]        bits_left_q, bits_left_d;
    logic [DATA_WIDTH-1:0] cur_q, cur_d;
    logic                  cur_valid_q, cur_valid_d;
    logic [CNT_W-1:0]      cur_cnt_q, cur_cnt_d;
    logic [DATA_WIDTH-1:0] buf_q, buf_d;
    logic                  buf_valid_q, buf_valid_d;
    logic                  ready_q, ready_d;
    logic                  sdo_q, sdo_d;
    logic                  done_q, done_d;
    logic                  underrun_q, underrun_d;
    logic                  accept;
    logic                  buf_take;

    always_ff @(posedge clk) begin
        if (!rstn) begin
            state_q     <= IDLE;
            bits_left_q <= '0;
            cur_q       <= '0;
            cur_valid_q <= 1'b0;
            cur_cnt_q   <= '0;
            buf_q       <= '0;
            buf_valid_q <= 1'b0;
            ready_q     <= 1'b0;
            sdo_q       <= 1'b0;
            done_q      <= 1'b0;
            underrun_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            bits_left_q <= bits_left_d;
            cur_q       <= cur_d;
            cur_valid_q <= cur_valid_d;
            cur_cnt_q   <= cur_cnt_d;
            buf_q       <= buf_d;
            buf_valid_q <= buf_valid_d;
            ready_q     <= ready_d;
            sdo_q       <= sdo_d;
            done_q      <= done_d;
            underrun_q  <= underrun_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        bits_left_d = bits_left_q;
        cur_d       = cur_q;
        cur_valid_d = cur_valid_q;
        cur_cnt_d   = cur_cnt_q;
        buf_d       = buf_q;
        buf_valid_d = buf_valid_q;
        done_d      = 1'b0;
        underrun_d  = 1'b0;
        accept      = 1'b0;
        buf_take    = 1'b0;

        case (state_q)
            IDLE: begin
                if (tx_start) begin
                    bits_left_d = {1'b0, tx_len} + BL_ONE;
                    state_d     = ACTIVE;
                end
            end

            ACTIVE: begin
                // ready_q high means buf is empty, so an accept never
                // collides with a buf->cur move in the same cycle.
                accept = fifo.valid_i && ready_q;

                if (tx_shift) begin
                    bits_left_d = bits_left_q - BL_ONE;
                    if (cur_valid_q) begin
                        cur_d     = cur_q << 1;
                        cur_cnt_d = cur_cnt_q - CNT_ONE;
                        if (cur_cnt_q == CNT_ONE) begin
                            // Word exhausted: hand over the prefetched word
                            // in the same cycle so no gap bit appears.
                            if (buf_valid_q) begin
                                cur_d     = buf_q;
                                cur_cnt_d = CNT_FULL;
                                buf_take  = 1'b1;
                            end else begin
                                cur_valid_d = 1'b0;
                            end
                        end
                    end else begin
                        underrun_d = 1'b1;
                    end
                end

                if (!cur_valid_q && buf_valid_q) begin
                    cur_d       = buf_q;
                    cur_valid_d = 1'b1;
                    cur_cnt_d   = CNT_FULL;
                    buf_take    = 1'b1;
                end

                if (buf_take) begin
                    buf_valid_d = 1'b0;
                end

                if (accept) begin
                    buf_d       = fifo.data_i;
                    buf_valid_d = 1'b1;
                end

                // Last bit shifted: drop any leftover bits and prefetched word.
                if (tx_shift && (bits_left_q == BL_ONE)) begin
                    state_d     = IDLE;
                    cur_valid_d = 1'b0;
                    buf_valid_d = 1'b0;
                    done_d      = 1'b1;
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase

        ready_d = (state_d == ACTIVE) && !buf_valid_d;
        sdo_d   = cur_valid_d & cur_d[DATA_WIDTH-1];
    end

    assign fifo.ready_o = ready_q;
    assign sdo          = sdo_q;
    assign tx_busy      = (state_q == ACTIVE);
    assign tx_done      = done_q;
    assign underrun     = underrun_q;

endmodule

// File: tb/tb_spi_slave_tx_serializer.sv
module tb_spi_slave_tx_serializer;

    localparam int DW = 8;
    localparam int LW = 8;

    logic          clk = 1'b0;
    logic          rstn = 1'b0;
    logic          tx_start = 1'b0;
    logic [LW-1:0] tx_len = '0;
    logic          tx_shift = 1'b0;
    logic          sdo;
    logic          tx_busy;
    logic          tx_done;
    logic          underrun;

    spi_slave_tx_serializer_if #(.DATA_WIDTH(DW)) fifo_if ();

    spi_slave_tx_serializer #(
        .DATA_WIDTH(DW),
        .LEN_W     (LW)
    ) dut (
        .clk     (clk),
        .rstn    (rstn),
        .fifo    (fifo_if),
        .tx_start(tx_start),
        .tx_len  (tx_len),
        .tx_shift(tx_shift),
        .sdo     (sdo),
        .tx_busy (tx_busy),
        .tx_done (tx_done),
        .underrun(underrun)
    );

    always #5 clk = ~clk;

    int vectors     = 0;
    int miscompares = 0;
    int hs_cnt      = 0;
    int done_cnt    = 0;
    int under_cnt   = 0;

    logic [DW-1:0] fifo_q[$];
    logic          fifo_en = 1'b1;

    // FIFO read-side model: pops on handshake, presents head 1 time unit later.
    initial begin
        fifo_if.valid_i = 1'b0;
        fifo_if.data_i  = '0;
        forever begin
            @(posedge clk);
            if (fifo_if.valid_i && fifo_if.ready_o) begin
                hs_cnt++;
                if (fifo_q.size() > 0) void'(fifo_q.pop_front());
            end
            #1;
            fifo_if.valid_i = fifo_en && (fifo_q.size() > 0);
            fifo_if.data_i  = (fifo_q.size() > 0) ? fifo_q[0] : '0;
        end
    end

    always @(negedge clk) begin
        if (tx_done === 1'b1) done_cnt++;
        if (underrun === 1'b1) under_cnt++;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic start_xfer(input logic [LW-1:0] len);
        tx_len   = len;
        tx_start = 1'b1;
        @(negedge clk);
        tx_start = 1'b0;
    endtask

    // Samples sdo before each strobe; returns on the negedge after the last one.
    task automatic shift_seq(input int n, input int spacing, output logic [255:0] seen);
        seen = '0;
        for (int i = 0; i < n; i++) begin
            seen     = {seen[254:0], sdo};
            tx_shift = 1'b1;
            @(negedge clk);
            tx_shift = 1'b0;
            if (i < n - 1) repeat (spacing - 1) @(negedge clk);
        end
    endtask

    task automatic test_reset;
        rstn = 1'b0;
        repeat (3) @(negedge clk);
        vectors++;
        if ({sdo, tx_busy, tx_done, underrun, fifo_if.ready_o} !== 5'b00000) begin
            miscompares++;
            $display("FAIL reset_outputs: got %b want 00000",
                     {sdo, tx_busy, tx_done, underrun, fifo_if.ready_o});
        end
        rstn = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_basic;
        logic [255:0] seen;
        int hs0, un0, dn0;
        fifo_q.push_back(8'hA5);
        repeat (3) @(negedge clk);
        hs0 = hs_cnt; un0 = under_cnt; dn0 = done_cnt;
        vectors++;
        if (fifo_if.ready_o !== 1'b0) begin
            miscompares++;
            $display("FAIL basic_idle_ready: got %b want 0", fifo_if.ready_o);
        end
        start_xfer(8'd7);
        repeat (2) @(negedge clk);
        shift_seq(8, 3, seen);
        vectors++;
        if ({tx_done, tx_busy, sdo} !== 3'b100) begin
            miscompares++;
            $display("FAIL basic_end: got done/busy/sdo %b want 100", {tx_done, tx_busy, sdo});
        end
        @(negedge clk);
        vectors++;
        if (tx_done !== 1'b0) begin
            miscompares++;
            $display("FAIL basic_done_pulse: got %b want 0", tx_done);
        end
        repeat (2) @(negedge clk);
        vectors++;
        if (seen[7:0] !== 8'hA5) begin
            miscompares++;
            $display("FAIL basic_bits: got %h want a5", seen[7:0]);
        end
        vectors++;
        if ({hs_cnt - hs0, under_cnt - un0, done_cnt - dn0} !== {32'd1, 32'd0, 32'd1}) begin
            miscompares++;
            $display("FAIL basic_counts: got hs=%0d un=%0d done=%0d want 1 0 1",
                     hs_cnt - hs0, under_cnt - un0, done_cnt - dn0);
        end
    endtask

    task automatic test_back_to_back;
        logic [255:0] seen;
        int hs0, un0;
        hs0 = hs_cnt; un0 = under_cnt;
        fifo_q.push_back(8'hF0);
        fifo_q.push_back(8'h0F);
        start_xfer(8'd15);
        repeat (2) @(negedge clk);
        shift_seq(16, 1, seen);
        vectors++;
        if (tx_done !== 1'b1) begin
            miscompares++;
            $display("FAIL b2b_done: got %b want 1", tx_done);
        end
        repeat (2) @(negedge clk);
        vectors++;
        if (seen[15:0] !== 16'hF00F) begin
            miscompares++;
            $display("FAIL b2b_bits: got %h want f00f", seen[15:0]);
        end
        vectors++;
        if ({hs_cnt - hs0, under_cnt - un0} !== {32'd2, 32'd0}) begin
            miscompares++;
            $display("FAIL b2b_counts: got hs=%0d un=%0d want 2 0", hs_cnt - hs0, under_cnt - un0);
        end
    endtask

    task automatic test_partial;
        logic [255:0] seen;
        int dn0;
        dn0 = done_cnt;
        fifo_q.push_back(8'hC3);
        start_xfer(8'd3);
        repeat (2) @(negedge clk);
        shift_seq(4, 1, seen);
        vectors++;
        if ({seen[3:0], tx_done} !== {4'hC, 1'b1}) begin
            miscompares++;
            $display("FAIL partial_bits: got %b done=%b want 1100 done=1", seen[3:0], tx_done);
        end
        repeat (2) @(negedge clk);
        fifo_q.push_back(8'h80);
        start_xfer(8'd0);
        repeat (2) @(negedge clk);
        vectors++;
        if (sdo !== 1'b1) begin
            miscompares++;
            $display("FAIL partial_fresh_sdo: got %b want 1", sdo);
        end
        shift_seq(1, 1, seen);
        vectors++;
        if ({tx_done, tx_busy} !== 2'b10) begin
            miscompares++;
            $display("FAIL partial_one_bit: got done/busy %b want 10", {tx_done, tx_busy});
        end
        repeat (2) @(negedge clk);
        vectors++;
        if (done_cnt - dn0 !== 2) begin
            miscompares++;
            $display("FAIL partial_done_count: got %0d want 2", done_cnt - dn0);
        end
    endtask

    task automatic test_underrun;
        logic [255:0] seen;
        int un0, dn0, hs0;
        un0 = under_cnt; dn0 = done_cnt; hs0 = hs_cnt;
        start_xfer(8'd1);
        vectors++;
        if ({fifo_if.ready_o, tx_busy} !== 2'b11) begin
            miscompares++;
            $display("FAIL underrun_active: got ready/busy %b want 11", {fifo_if.ready_o, tx_busy});
        end
        shift_seq(2, 2, seen);
        vectors++;
        if ({underrun, tx_done, sdo, seen[1:0]} !== 5'b11000) begin
            miscompares++;
            $display("FAIL underrun_last: got un/done/sdo/bits %b want 11000",
                     {underrun, tx_done, sdo, seen[1:0]});
        end
        repeat (2) @(negedge clk);
        vectors++;
        if ({under_cnt - un0, done_cnt - dn0, hs_cnt - hs0} !== {32'd2, 32'd1, 32'd0}) begin
            miscompares++;
            $display("FAIL underrun_counts: got un=%0d done=%0d hs=%0d want 2 1 0",
                     under_cnt - un0, done_cnt - dn0, hs_cnt - hs0);
        end
    endtask

    task automatic test_ignored;
        logic [255:0] s1, s2;
        int hs0, un0, dn0;
        hs0 = hs_cnt; un0 = under_cnt; dn0 = done_cnt;
        fifo_q.push_back(8'h3C);
        for (int i = 0; i < 8; i++) begin
            tx_shift = (i % 2 == 1);
            fifo_en  = (i % 3 != 0);
            @(negedge clk);
            vectors++;
            if ({sdo, fifo_if.ready_o, tx_busy} !== 3'b000) begin
                miscompares++;
                $display("FAIL idle_quiet[%0d]: got sdo/ready/busy %b want 000",
                         i, {sdo, fifo_if.ready_o, tx_busy});
            end
        end
        tx_shift = 1'b0;
        fifo_en  = 1'b1;
        repeat (2) @(negedge clk);
        vectors++;
        if ({hs_cnt - hs0, under_cnt - un0, done_cnt - dn0} !== {32'd0, 32'd0, 32'd0}) begin
            miscompares++;
            $display("FAIL idle_counts: got hs=%0d un=%0d done=%0d want 0 0 0",
                     hs_cnt - hs0, under_cnt - un0, done_cnt - dn0);
        end
        start_xfer(8'd7);
        repeat (2) @(negedge clk);
        shift_seq(3, 1, s1);
        tx_len   = 8'd0;
        tx_start = 1'b1;
        @(negedge clk);
        tx_start = 1'b0;
        shift_seq(5, 1, s2);
        vectors++;
        if ({s1[2:0], s2[4:0], tx_done} !== {8'h3C, 1'b1}) begin
            miscompares++;
            $display("FAIL restart_ignored: got %b done=%b want 00111100 done=1",
                     {s1[2:0], s2[4:0]}, tx_done);
        end
        repeat (2) @(negedge clk);
        vectors++;
        if ({hs_cnt - hs0, done_cnt - dn0} !== {32'd1, 32'd1}) begin
            miscompares++;
            $display("FAIL restart_counts: got hs=%0d done=%0d want 1 1",
                     hs_cnt - hs0, done_cnt - dn0);
        end
    endtask

    task automatic test_reset_mid;
        logic [255:0] seen;
        int dn0;
        dn0 = done_cnt;
        fifo_q.push_back(8'h96);
        start_xfer(8'd7);
        repeat (2) @(negedge clk);
        shift_seq(3, 1, seen);
        vectors++;
        if (seen[2:0] !== 3'b100) begin
            miscompares++;
            $display("FAIL rstmid_pre_bits: got %b want 100", seen[2:0]);
        end
        rstn = 1'b0;
        @(negedge clk);
        vectors++;
        if ({tx_busy, fifo_if.ready_o, sdo, tx_done} !== 4'b0000) begin
            miscompares++;
            $display("FAIL rstmid_state: got busy/ready/sdo/done %b want 0000",
                     {tx_busy, fifo_if.ready_o, sdo, tx_done});
        end
        rstn = 1'b1;
        repeat (2) @(negedge clk);
        vectors++;
        if (done_cnt - dn0 !== 0) begin
            miscompares++;
            $display("FAIL rstmid_no_done: got %0d want 0", done_cnt - dn0);
        end
        fifo_q.delete();
        fifo_q.push_back(8'h5A);
        start_xfer(8'd7);
        repeat (2) @(negedge clk);
        shift_seq(8, 2, seen);
        vectors++;
        if ({seen[7:0], tx_done} !== {8'h5A, 1'b1}) begin
            miscompares++;
            $display("FAIL rstmid_after: got %h done=%b want 5a done=1", seen[7:0], tx_done);
        end
        repeat (2) @(negedge clk);
    endtask

    task automatic test_max_len;
        logic [255:0] seen, last, expd;
        logic [DW-1:0] w;
        int hs0, un0, dn0;
        hs0 = hs_cnt; un0 = under_cnt; dn0 = done_cnt;
        expd = '0;
        for (int k = 0; k < 32; k++) begin
            w = 8'(k * 29 + 7);
            fifo_q.push_back(w);
            expd = {expd[247:0], w};
        end
        start_xfer(8'hFF);
        repeat (2) @(negedge clk);
        shift_seq(255, 1, seen);
        vectors++;
        if ({tx_busy, tx_done} !== 2'b10) begin
            miscompares++;
            $display("FAIL maxlen_not_early: got busy/done %b want 10", {tx_busy, tx_done});
        end
        shift_seq(1, 1, last);
        vectors++;
        if ({seen[254:0], last[0]} !== expd) begin
            miscompares++;
            $display("FAIL maxlen_bits: got %h want %h", {seen[254:0], last[0]}, expd);
        end
        vectors++;
        if (tx_done !== 1'b1) begin
            miscompares++;
            $display("FAIL maxlen_done: got %b want 1", tx_done);
        end
        repeat (2) @(negedge clk);
        vectors++;
        if ({hs_cnt - hs0, under_cnt - un0, done_cnt - dn0} !== {32'd32, 32'd0, 32'd1}) begin
            miscompares++;
            $display("FAIL maxlen_counts: got hs=%0d un=%0d done=%0d want 32 0 1",
                     hs_cnt - hs0, under_cnt - un0, done_cnt - dn0);
        end
    endtask

    initial begin
        @(negedge clk);
        test_reset();
        test_basic();
        test_back_to_back();
        test_partial();
        test_underrun();
        test_ignored();
        test_reset_mid();
        test_max_len();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
